// File: rtl/seq_counter_pkg.sv
// Shared constants and helpers for the table-driven sequence counter.
// Optional table programming is enabled by defining SEQ_CNT_WRITE_EN.
package seq_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

    // Reset / ROM content of entry i: i mod 2^width.
    function automatic int default_entry(input int i, input int width);
        if (width >= 31) begin
            return i;
        end
        return i % (1 << width);
    endfunction

endpackage

// File: rtl/seq_counter_table.sv
// DEPTH x WIDTH sequence table with an asynchronous read port.
// With SEQ_CNT_WRITE_EN defined the table is a register array with a
// synchronous write port and reset-restored contents; otherwise it is a
// constant ROM holding the default contents.
module seq_counter_table
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 6,
    localparam int IDX_W = $clog2(DEPTH)
) (
`ifdef SEQ_CNT_WRITE_EN
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
`endif
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] rom [DEPTH];

    // Default table contents, one constant per entry.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = WIDTH'(default_entry(g, WIDTH));
    end

`ifdef SEQ_CNT_WRITE_EN
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    // Writes outside the table are dropped.
    assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);

    // Reset restores the default contents and beats any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= rom[i];
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read of the current entry.
    assign rd_data = mem[rd_addr];
`else
    // Asynchronous read of the constant table.
    assign rd_data = rom[rd_addr];
`endif

endmodule

// File: rtl/seq_counter.sv
// Table-driven sequence counter: steps idx up or down through a DEPTH-entry
// table, wrapping or parking at the end, and presents table[idx] on Q.
// Define SEQ_CNT_WRITE_EN to add the run-time table write port.
module seq_counter
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 6,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
`ifdef SEQ_CNT_WRITE_EN
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [IDX_W-1:0] idx,
    output logic             tc,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] idx_r, idx_nxt, end_idx;
    logic             done_r, done_nxt;
    logic             at_end, load_ok;

    // The end position depends on the current direction only.
    assign end_idx = (dir == DIR_UP) ? LAST_IDX : '0;
    assign at_end  = (idx_r == end_idx);
    assign load_ok = (int'(load_idx) < DEPTH);

    // Terminal count: an enabled step taken from the end position.
    assign tc = enable & ~load & ~reset & at_end;

    // Next index / done: load beats enable; at the end either wrap or park.
    always_comb begin
        idx_nxt  = idx_r;
        done_nxt = done_r;
        if (load) begin
            idx_nxt  = load_ok ? load_idx : '0;
            done_nxt = 1'b0;
        end else if (enable) begin
            if (!at_end) begin
                idx_nxt  = (dir == DIR_UP) ? idx_r + IDX_W'(1) : idx_r - IDX_W'(1);
                done_nxt = 1'b0;
            end else if (mode == MODE_WRAP) begin
                idx_nxt  = (dir == DIR_UP) ? '0 : LAST_IDX;
                done_nxt = 1'b0;
            end else begin
                done_nxt = 1'b1;
            end
        end
    end

    // Index and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r  <= '0;
            done_r <= 1'b0;
        end else begin
            idx_r  <= idx_nxt;
            done_r <= done_nxt;
        end
    end

    assign idx  = idx_r;
    assign done = done_r;

    seq_counter_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
`ifdef SEQ_CNT_WRITE_EN
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_addr (idx_r),
        .rd_data (Q)
    );

endmodule

// File: tb/tb_seq_counter.sv
// Directed testbench for seq_counter (WIDTH=3, DEPTH=6).
// Table-write scenarios are included when SEQ_CNT_WRITE_EN is defined.
module tb_seq_counter;

    localparam int WIDTH = 3;
    localparam int DEPTH = 6;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             dir;
    logic             mode;
    logic             load;
    logic [IDX_W-1:0] load_idx;
`ifdef SEQ_CNT_WRITE_EN
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
`endif
    logic [WIDTH-1:0] Q;
    logic [IDX_W-1:0] idx;
    logic             tc;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDX_W-1:0] exp_q[$];

    seq_counter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_idx (load_idx),
`ifdef SEQ_CNT_WRITE_EN
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`endif
        .Q        (Q),
        .idx      (idx),
        .tc       (tc),
        .done     (done)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; return 1 time unit after the following falling edge.
    task automatic step_clk();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_ctrl(input logic en, input logic d, input logic m,
                              input logic ld, input logic [IDX_W-1:0] li);
        enable   = en;
        dir      = d;
        mode     = m;
        load     = ld;
        load_idx = li;
    endtask

    // Default table entry model: i mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] def_q(input int i);
        return WIDTH'(i % (1 << WIDTH));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive_ctrl(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step_clk();
        step_clk();
        // idx=0, dir=down, enable=1: only reset keeps tc low.
        n_checks++;
        if (tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tc: got %b expected 0", tc);
        end
        reset = 1'b0;
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        n_checks++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d expected 0", idx);
        end
        n_checks++;
        if (Q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_q: got %0d expected 0", Q);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
    endtask

    // Walk the expected index queue, one enabled step per entry.
    task automatic check_walk(input string name, input logic [IDX_W-1:0] end_pos);
        logic [IDX_W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (idx !== e) begin
                n_fail++;
                $display("FAIL %s_idx: got %0d expected %0d", name, idx, e);
            end
            n_checks++;
            if (Q !== def_q(int'(e))) begin
                n_fail++;
                $display("FAIL %s_q: got %0d expected %0d", name, Q, def_q(int'(e)));
            end
            n_checks++;
            if (tc !== (e == end_pos)) begin
                n_fail++;
                $display("FAIL %s_tc: got %b expected %b at idx %0d", name, tc, (e == end_pos), e);
            end
            step_clk();
        end
    endtask

    task automatic test_up_wrap();
        drive_ctrl(1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        check_walk("up_wrap", 3'd5);
    endtask

    task automatic test_down_wrap();
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        step_clk();
        drive_ctrl(1'b1, 1'b1, 1'b0, 1'b0, '0);
        #1;
        exp_q = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
        check_walk("down_wrap", 3'd0);
    endtask

    task automatic test_stop();
        logic [IDX_W-1:0] ei [5];
        logic             ed [5];
        logic             et [5];
        ei = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        et = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        drive_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        step_clk();
        drive_ctrl(1'b1, 1'b0, 1'b1, 1'b0, '0);
        #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (idx !== ei[c] || done !== ed[c] || tc !== et[c]) begin
                n_fail++;
                $display("FAIL stop_cycle%0d: got idx=%0d done=%b tc=%b expected idx=%0d done=%b tc=%b",
                         c, idx, done, tc, ei[c], ed[c], et[c]);
            end
            step_clk();
        end
        // Reverse while parked: end becomes 0, so no tc and a step down.
        dir = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_reverse_pre: got tc=%b done=%b expected tc=0 done=1", tc, done);
        end
        step_clk();
        n_checks++;
        if (idx !== 3'd4 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_reverse: got idx=%0d done=%b expected idx=4 done=0", idx, done);
        end
    endtask

    task automatic test_load();
        // Load with enable: load wins, tc suppressed.
        drive_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        #1;
        n_checks++;
        if (tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_tc: got %b expected 0", tc);
        end
        step_clk();
        n_checks++;
        if (idx !== 3'd3 || Q !== def_q(3) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_3: got idx=%0d Q=%0d done=%b expected idx=3 Q=%0d done=0",
                     idx, Q, done, def_q(3));
        end
        // Hold with enable=0.
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step_clk();
        step_clk();
        n_checks++;
        if (idx !== 3'd3) begin
            n_fail++;
            $display("FAIL hold: got idx=%0d expected 3", idx);
        end
        // Out-of-range loads go to 0.
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        step_clk();
        n_checks++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL load_7: got idx=%0d expected 0", idx);
        end
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        step_clk();
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        step_clk();
        n_checks++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL load_6: got idx=%0d expected 0", idx);
        end
        // Reset beats load.
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
        step_clk();
        drive_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        n_checks++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_over_load: got idx=%0d expected 0", idx);
        end
    endtask

`ifdef SEQ_CNT_WRITE_EN
    task automatic sweep_table(input string name, input logic [WIDTH-1:0] tbl [DEPTH]);
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        step_clk();
        drive_ctrl(1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        for (int c = 0; c < DEPTH; c++) begin
            n_checks++;
            if (Q !== tbl[c]) begin
                n_fail++;
                $display("FAIL %s_entry%0d: got %0d expected %0d", name, c, Q, tbl[c]);
            end
            step_clk();
        end
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_write();
        logic [WIDTH-1:0] prog [DEPTH];
        logic [WIDTH-1:0] dflt [DEPTH];
        prog = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd2};
        dflt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = IDX_W'(a);
            wr_data = prog[a];
            step_clk();
        end
        wr_en = 1'b0;
        // Stepping from 0: Q 0,1,3,5,7,2,0.
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        step_clk();
        drive_ctrl(1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if (Q !== prog[c % DEPTH]) begin
                n_fail++;
                $display("FAIL prog_step%0d: got %0d expected %0d", c, Q, prog[c % DEPTH]);
            end
            step_clk();
        end
        // idx is now 1; write entry 2 while stepping onto it.
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 3'd6;
        step_clk();
        wr_en = 1'b0;
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        n_checks++;
        if (idx !== 3'd2 || Q !== 3'd6) begin
            n_fail++;
            $display("FAIL write_with_step: got idx=%0d Q=%0d expected idx=2 Q=6", idx, Q);
        end
        prog[2] = 3'd6;
        // Out-of-range write is ignored.
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 3'd4;
        step_clk();
        wr_en = 1'b0;
        sweep_table("after_addr6", prog);
        // Reset overrides a simultaneous write and restores defaults.
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 3'd5;
        step_clk();
        reset = 1'b0;
        wr_en = 1'b0;
        sweep_table("after_reset", dflt);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifdef SEQ_CNT_WRITE_EN
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
`endif
        step_clk();
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_stop();
        test_load();
`ifdef SEQ_CNT_WRITE_EN
        test_write();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_counter.md
Name: seq_counter

Overview:
Parametrised table-driven sequence counter. It steps an index through a DEPTH-entry sequence table and outputs the WIDTH-bit code stored at the current index.
- Supports up/down direction, wrap or stop-at-end mode, synchronous index load and a terminal-count flag.
- Optional run-time programming of the table.
- Drop-in generator for state/code sequences in the lab datapaths; general replacement for fixed hard-coded sequence counters.

Parameters:
WIDTH, 3, bit width of each sequence code and of Q.
DEPTH, 6, number of sequence entries (>=2).
IDX_W, $clog2(DEPTH), index width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable  in  1  advance index one step this cycle
dir  in  1  0 = up (idx+1), 1 = down (idx-1)
mode  in  1  0 = wrap, 1 = stop at end
load  in  1  load idx from load_idx
load_idx  in  IDX_W  index to load
wr_en  in  1  table write strobe (SEQ_CNT_WRITE_EN only)
wr_addr  in  IDX_W  table write address (SEQ_CNT_WRITE_EN only)
wr_data  in  WIDTH  table write data (SEQ_CNT_WRITE_EN only)
Q  out  WIDTH  table[idx]
idx  out  IDX_W  current index
tc  out  1  terminal count
done  out  1  stop mode parked at end

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: idx=0, done=0, table[i] = i mod 2^WIDTH for all i. Q therefore reads 0 after reset.
- Q is a combinational read of table[idx]. Q changes in the same cycle idx or the addressed entry changes.
- Per-edge priority: reset > load > enable.
- load=1:
  - idx <= load_idx if load_idx < DEPTH, else idx <= 0.
  - done <= 0.
  - enable is ignored that cycle.
- enable=1, load=0:
  - End position is DEPTH-1 when dir=0, and 0 when dir=1.
  - If idx != end: idx steps by ±1 and done <= 0.
  - If idx == end and mode=0: idx wraps to the opposite end (DEPTH-1→0 up, 0→DEPTH-1 down).
  - If idx == end and mode=1: idx holds and done <= 1.
- enable=0, load=0: idx and done hold.
- tc = enable & ~load & ~reset & (idx == end for current dir). Combinational, one cycle wide per qualifying step. In stop mode tc stays high each enabled cycle while parked.
- Reversing dir while done=1 makes the other end the target. The next enabled step moves idx and clears done.
- mode changes take effect on the next enabled step; no state is flushed.
- Latency: idx/Q update one edge after enable/load. There is no pipeline.
- Table writes (when the feature is present):
  - table[wr_addr] <= wr_data on the edge; wr_addr >= DEPTH is ignored.
  - A write plus a step in the same cycle both take effect.
  - If wr_addr equals the new idx, Q shows wr_data after the edge.
  - reset overrides any write and restores the default table.

Optional Feature:
SEQ_CNT_WRITE_EN
- Defined: wr_en/wr_addr/wr_data ports exist and the table is a writable register array, initialised by reset as above.
- Undefined: the write ports are absent and the table is a constant ROM holding the reset contents. Q = f(idx) only, and reset affects only idx and done.

Decomposition:
- Package seq_counter_pkg holds:
  - DIR_UP/DIR_DOWN and MODE_WRAP/MODE_STOP localparams.
  - A default_entry(i, width) function used for the reset/ROM contents.
- One natural sub-module, seq_counter_table: the DEPTH×WIDTH storage with async read port, plus the sync write port under the macro. The index/direction/done control stays in seq_counter.

Test Plan:
- Reset then enable=1, dir=0, mode=0 for 8 cycles (defaults) -> idx 0,1,2,3,4,5,0,1; Q identical; tc high exactly in the cycles with idx=5.
- dir=1, mode=0 from idx=0 -> idx 5,4,3…; tc high in the cycle with idx=0 and enable=1.
- mode=1, dir=0, enable held -> idx parks at 5, done=1 from the following edge, tc stays 1. Then dir=1 -> idx 4, done=0.
- load=1, load_idx=3 together with enable=1 -> idx=3 next edge, no step. load_idx=7 -> idx=0. reset=1 together with load -> idx=0.
- With SEQ_CNT_WRITE_EN, program table to 0,1,3,5,7,2, then step from 0 -> Q 0,1,3,5,7,2,0. Write addr 2=6 in the same cycle idx steps 1→2 -> Q=6. Write to addr 6 -> no change.
- Without SEQ_CNT_WRITE_EN, the full up/down wrap sweep matches the default_entry values; the build has no wr_* ports.
